// File: rtl/dmem_arbiter_if.sv
// Requester-side port bundle for dmem_arbiter: one instance per requester.
// The master side issues a single transaction; the slave side (the arbiter)
// grants it and returns a one-cycle completion pulse with data and error.
interface dmem_arbiter_if;
  logic        req;
  logic [1:0]  write_mem;
  logic [2:0]  read_mem;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, write_mem, read_mem, address, write_data,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, write_mem, read_mem, address, write_data,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single data memory.
// Each transaction runs IDLE (grant) -> ACCESS (memory driven) -> RESP
// (rvalid pulse). Ties are broken round-robin; accesses that would run past
// MEM_BYTES never reach the memory and complete with err=1.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       m0,
  dmem_arbiter_if.slave       m1,
  output logic [1:0]          mem_write_mem,
  output logic [2:0]          mem_read_mem,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_write_data,
  input  logic [31:0]         mem_out_mem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [1:0]  wmem_q, wmem_d;
  logic [2:0]  rmem_q, rmem_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        gnt0, gnt1;
  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        oor, do_write, do_read;

  function automatic logic [2:0] size_of(input logic [1:0] enc);
    case (enc)
      2'b01:   return 3'd4;
      2'b10:   return 3'd2;
      2'b11:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  // Classify the latched transaction: size, bounds check (33-bit, no wrap), store vs load.
  always_comb begin
    size     = (wmem_q != 2'b00) ? size_of(wmem_q) : size_of(rmem_q[1:0]);
    end_addr = {1'b0, addr_q} + {30'd0, size};
    oor      = (size != 3'd0) && (end_addr > 33'(MEM_BYTES));
    do_write = !oor && (wmem_q != 2'b00);
    do_read  = !oor && (wmem_q == 2'b00) && (rmem_q[1:0] != 2'b00);
  end

  // Round-robin grant, only while idle and out of reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst && state_q == IDLE) begin
      if (m0.req && m1.req) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = m0.req;
        gnt1 = m1.req;
      end
    end
  end

  // Next state, field latching and memory drive.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    id_d           = id_q;
    wmem_d         = wmem_q;
    rmem_d         = rmem_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    mem_write_mem  = '0;
    mem_read_mem   = '0;
    mem_address    = '0;
    mem_write_data = '0;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          id_d    = gnt1;
          last_d  = gnt1;
          wmem_d  = gnt1 ? m1.write_mem  : m0.write_mem;
          rmem_d  = gnt1 ? m1.read_mem   : m0.read_mem;
          addr_d  = gnt1 ? m1.address    : m0.address;
          wdata_d = gnt1 ? m1.write_data : m0.write_data;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_write_mem  = do_write ? wmem_q : 2'b00;
        mem_read_mem   = do_read ? rmem_q : 3'b000;
        mem_address    = (do_write || do_read) ? addr_q : '0;
        mem_write_data = do_write ? wdata_q : '0;
        rdata_d        = do_read ? mem_out_mem : '0;
        err_d          = oor;
        state_d        = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched-transaction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      wmem_q  <= '0;
      rmem_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      wmem_q  <= wmem_d;
      rmem_q  <= rmem_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = (state_q == RESP) && !id_q;
  assign m1.rvalid = (state_q == RESP) && id_q;
  assign m0.rdata  = m0.rvalid ? rdata_q : '0;
  assign m1.rdata  = m1.rvalid ? rdata_q : '0;
  assign m0.err    = m0.rvalid && err_q;
  assign m1.err    = m1.rvalid && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory on the memory side, a
// transaction-level scoreboard checked every cycle, and directed scenarios
// with literal expected results.
module tb_dmem_arbiter;
  localparam int unsigned MEM_BYTES = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mem_write_mem;
  logic [2:0]  mem_read_mem;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_out_mem;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .rst            (rst),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_write_mem  (mem_write_mem),
    .mem_read_mem   (mem_read_mem),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_out_mem    (mem_out_mem)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no response within budget (t=%0t)", name, $time);
  endtask

  function automatic int sz_of(input logic [1:0] e);
    return (e == 2'b01) ? 4 : (e == 2'b10) ? 2 : (e == 2'b11) ? 1 : 0;
  endfunction

  function automatic logic [31:0] mem_load(input logic [7:0] m [MEM_BYTES],
                                           input logic [2:0] r, input logic [31:0] a);
    int unsigned i;
    logic [7:0] b0, b1, b2, b3;
    i  = a % MEM_BYTES;
    b0 = m[i];
    b1 = m[(i + 1) % MEM_BYTES];
    b2 = m[(i + 2) % MEM_BYTES];
    b3 = m[(i + 3) % MEM_BYTES];
    case (r[1:0])
      2'b01:   return {b3, b2, b1, b0};
      2'b10:   return {{16{r[2] & b1[7]}}, b1, b0};
      2'b11:   return {{24{r[2] & b0[7]}}, b0};
      default: return 32'h0;
    endcase
  endfunction

  // Data memory seen by the DUT: combinational load, store at the clock edge.
  logic [7:0] dut_mem [MEM_BYTES] = '{default: 8'h00};
  assign mem_out_mem = (mem_read_mem[1:0] != 2'b00) ?
                       mem_load(dut_mem, mem_read_mem, mem_address) : 32'hA5A5_A5A5;
  always @(posedge clk) begin
    if (mem_write_mem != 2'b00)
      for (int k = 0; k < sz_of(mem_write_mem); k++)
        dut_mem[(int'(mem_address % MEM_BYTES) + k) % MEM_BYTES] <= mem_write_data[8*k +: 8];
  end

  // Scoreboard: one outstanding transaction; memory at grant+1, response at grant+2.
  logic [7:0]  ref_mem [MEM_BYTES] = '{default: 8'h00};
  int          cyc = 0;
  bit          pend = 0;
  int          p_g;
  bit          p_id;
  logic [1:0]  p_w;
  logic [2:0]  p_r;
  logic [31:0] p_a, p_d, x_rdata;
  bit          x_err;
  bit          last_srv = 1;

  always @(negedge clk) begin
    bit g0, g1, v0, v1, pick;
    logic [1:0]  e_wm;
    logic [2:0]  e_rm;
    logic [31:0] e_a, e_wd;
    int          sz;
    bit          oor;
    g0 = 0; g1 = 0; v0 = 0; v1 = 0;
    e_wm = '0; e_rm = '0; e_a = '0; e_wd = '0;
    if (!rst) begin
      pend     = 0;
      last_srv = 1;
    end else if (!pend) begin
      if (m0_if.req || m1_if.req) begin
        pick = (m0_if.req && m1_if.req) ? !last_srv : m1_if.req;
        g0 = !pick; g1 = pick;
        pend = 1; p_g = cyc; p_id = pick; last_srv = pick;
        p_w = pick ? m1_if.write_mem  : m0_if.write_mem;
        p_r = pick ? m1_if.read_mem   : m0_if.read_mem;
        p_a = pick ? m1_if.address    : m0_if.address;
        p_d = pick ? m1_if.write_data : m0_if.write_data;
      end
    end else if (cyc == p_g + 1) begin
      sz = (p_w != 2'b00) ? sz_of(p_w) : sz_of(p_r[1:0]);
      oor = (sz != 0) && (longint'(p_a) + sz > MEM_BYTES);
      x_err = oor;
      x_rdata = '0;
      if (!oor && p_w != 2'b00) begin
        e_wm = p_w; e_a = p_a; e_wd = p_d;
        for (int k = 0; k < sz; k++)
          ref_mem[(int'(p_a % MEM_BYTES) + k) % MEM_BYTES] = p_d[8*k +: 8];
      end else if (!oor && p_r[1:0] != 2'b00) begin
        e_rm = p_r; e_a = p_a;
        x_rdata = mem_load(ref_mem, p_r, p_a);
      end
    end else if (cyc == p_g + 2) begin
      v0 = !p_id; v1 = p_id;
      pend = 0;
    end
    check("m0_gnt", 32'(m0_if.gnt), 32'(g0));
    check("m1_gnt", 32'(m1_if.gnt), 32'(g1));
    check("m0_rvalid", 32'(m0_if.rvalid), 32'(v0));
    check("m1_rvalid", 32'(m1_if.rvalid), 32'(v1));
    check("m0_rdata", m0_if.rdata, v0 ? x_rdata : 32'h0);
    check("m1_rdata", m1_if.rdata, v1 ? x_rdata : 32'h0);
    check("m0_err", 32'(m0_if.err), 32'(v0 & x_err));
    check("m1_err", 32'(m1_if.err), 32'(v1 & x_err));
    check("mem_write_mem", 32'(mem_write_mem), 32'(e_wm));
    check("mem_read_mem", 32'(mem_read_mem), 32'(e_rm));
    check("mem_address", mem_address, e_a);
    check("mem_write_data", mem_write_data, e_wd);
    cyc++;
  end

  task automatic drive(input bit id, input logic q, input logic [1:0] w, input logic [2:0] r,
                       input logic [31:0] a, input logic [31:0] d);
    if (id) begin
      m1_if.req = q; m1_if.write_mem = w; m1_if.read_mem = r;
      m1_if.address = a; m1_if.write_data = d;
    end else begin
      m0_if.req = q; m0_if.write_mem = w; m0_if.read_mem = r;
      m0_if.address = a; m0_if.write_data = d;
    end
  endtask

  // One transaction; lat counts cycles from the grant cycle to the rvalid cycle.
  task automatic do_txn(input bit id, input logic [1:0] w, input logic [2:0] r,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    int n;
    rd = '0; e = 1'b0; lat = -1;
    @(posedge clk); #1;
    drive(id, 1'b1, w, r, a, d);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(id ? m1_if.gnt : m0_if.gnt) && n < 20);
    if (!(id ? m1_if.gnt : m0_if.gnt)) begin
      timeout("gnt_wait");
      drive(id, 1'b0, 2'b00, 3'b000, '0, '0);
      return;
    end
    @(posedge clk); #1;
    // Fields after the grant must be ignored.
    drive(id, 1'b0, 2'b11, 3'b111, 32'hFFFF_FFFC, 32'h5555_5555);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(id ? m1_if.rvalid : m0_if.rvalid) && n < 10);
    if (!(id ? m1_if.rvalid : m0_if.rvalid)) begin
      timeout("rvalid_wait");
      return;
    end
    lat = n;
    rd  = id ? m1_if.rdata : m0_if.rdata;
    e   = id ? m1_if.err : m0_if.err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, n, ng;
    int          gid [4];
    int          gc [4];
    bit          saw;

    // Both requesters held from reset: expect m0, m1, m0, m1 three cycles apart.
    drive(0, 1'b1, 2'b00, 3'b001, 32'h0, 32'h0);
    drive(1, 1'b1, 2'b00, 3'b001, 32'h4, 32'h0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    ng = 0; n = 0;
    while (ng < 4 && n < 20) begin
      @(negedge clk); n++;
      if (m0_if.gnt || m1_if.gnt) begin
        gid[ng] = int'(m1_if.gnt); gc[ng] = n; ng++;
      end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 3'b000, '0, '0);
    drive(1, 1'b0, 2'b00, 3'b000, '0, '0);
    check("tie_grants", 32'(ng), 32'd4);
    check("tie_first_cycle", 32'(gc[0]), 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("tie_id%0d", i), 32'(gid[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++)
      check($sformatf("tie_gap%0d", i), 32'(gc[i] - gc[i-1]), 32'd3);
    repeat (3) @(posedge clk);

    // Word store then word load.
    do_txn(0, 2'b01, 3'b000, 32'h10, 32'hDEAD_BEEF, rd, e, lat);
    check("st_lat", 32'(lat), 32'd2);
    check("st_rdata", rd, 32'h0);
    do_txn(0, 2'b00, 3'b001, 32'h10, 32'h0, rd, e, lat);
    check("ld_lat", 32'(lat), 32'd2);
    check("ld_rdata", rd, 32'hDEAD_BEEF);
    check("ld_err", 32'(e), 32'd0);

    // Byte 0x80 at 0x20, signed and unsigned loads.
    do_txn(1, 2'b11, 3'b000, 32'h20, 32'h0000_0080, rd, e, lat);
    do_txn(1, 2'b00, 3'b111, 32'h20, 32'h0, rd, e, lat);
    check("lb_signed", rd, 32'hFFFF_FF80);
    do_txn(1, 2'b00, 3'b011, 32'h20, 32'h0, rd, e, lat);
    check("lb_unsigned", rd, 32'h0000_0080);

    // Bounds.
    do_txn(0, 2'b00, 3'b001, 32'd126, 32'h0, rd, e, lat);
    check("oor126_err", 32'(e), 32'd1);
    check("oor126_rdata", rd, 32'h0);
    do_txn(0, 2'b00, 3'b001, 32'hFFFF_FFFE, 32'h0, rd, e, lat);
    check("oor_wrap_err", 32'(e), 32'd1);
    do_txn(0, 2'b00, 3'b001, 32'd124, 32'h0, rd, e, lat);
    check("inrange124_err", 32'(e), 32'd0);
    do_txn(1, 2'b11, 3'b000, 32'd127, 32'h0000_007F, rd, e, lat);
    check("inrange127_err", 32'(e), 32'd0);

    // Store and load requested together: store only.
    do_txn(0, 2'b01, 3'b001, 32'h08, 32'h1234_5678, rd, e, lat);
    check("both_rdata", rd, 32'h0);
    check("both_err", 32'(e), 32'd0);
    do_txn(0, 2'b00, 3'b001, 32'h08, 32'h0, rd, e, lat);
    check("both_reload", rd, 32'h1234_5678);

    // Neither store nor load: still completes.
    do_txn(1, 2'b00, 3'b100, 32'h7FFF_FFFF, 32'h0, rd, e, lat);
    check("none_lat", 32'(lat), 32'd2);
    check("none_err", 32'(e), 32'd0);

    // Unaligned half store, signed half load.
    do_txn(1, 2'b10, 3'b000, 32'h31, 32'hABCD_8001, rd, e, lat);
    do_txn(0, 2'b00, 3'b110, 32'h31, 32'h0, rd, e, lat);
    check("lh_signed", rd, 32'hFFFF_8001);

    // Reset in the middle of an access aborts the store.
    @(posedge clk); #1;
    drive(1, 1'b1, 2'b01, 3'b000, 32'h40, 32'hCAFE_F00D);
    n = 0;
    do begin @(negedge clk); n++; end while (!m1_if.gnt && n < 20);
    if (!m1_if.gnt) timeout("abort_gnt_wait");
    @(posedge clk); #1;
    drive(1, 1'b0, 2'b00, 3'b000, '0, '0);
    check("abort_wm_access", 32'(mem_write_mem), 32'd1);
    #1 rst = 1'b0;
    #1 check("abort_wm_reset", 32'(mem_write_mem), 32'd0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    saw = 0;
    repeat (4) begin @(negedge clk); if (m1_if.rvalid) saw = 1; end
    check("abort_no_rvalid", 32'(saw), 32'd0);
    check("abort_mem40", {dut_mem[8'h43], dut_mem[8'h42], dut_mem[8'h41], dut_mem[8'h40]}, 32'h0);
    do_txn(1, 2'b00, 3'b001, 32'h40, 32'h0, rd, e, lat);
    check("abort_reload", rd, 32'h0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
